// File: rtl/msrv32_alu_wb_buf.sv
// msrv32_alu_wb_buf: two-entry skid buffer between the ALU and write-back.
// Holds result, rd and wr_en; registered ready, FIFO order, flush support.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   flush_in              drop stored entries and the current input
//   in_valid_in/ready_out upstream handshake
//   result_in, rd_addr_in, wr_en_in  incoming ALU result bundle
//   out_valid_out/ready_in downstream handshake
//   result_out, rd_addr_out, wr_en_out  head entry (wr_en gated for x0)
//   count_out             occupancy, 0..2
module msrv32_alu_wb_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [WIDTH-1:0] result_in,
    input  logic [4:0]       rd_addr_in,
    input  logic             wr_en_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic [4:0]       rd_addr_out,
    output logic             wr_en_out,
    output logic [1:0]       count_out
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [4:0]       rd;
        logic             we;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    cnt_e   count_q, count_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_e;

    logic accept;
    logic pop;

    assign in_e         = '{res: result_in, rd: rd_addr_in, we: wr_en_in};
    assign in_ready_out = (count_q != FULL) & ~rst_in;
    assign out_valid_out = (count_q != EMPTY);
    assign accept       = in_valid_in & in_ready_out;
    assign pop          = out_valid_out & out_ready_in;

    assign result_out  = head_q.res;
    assign rd_addr_out = head_q.rd;
    // x0 writes still drain through the buffer but never reach the regfile
    assign wr_en_out   = out_valid_out & head_q.we & (head_q.rd != 5'd0);
    assign count_out   = count_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        // A pop in the flush cycle needs no action: the head was already
        // presented downstream. Everything else, including the input, is lost.
        if (flush_in) begin
            count_d = EMPTY;
        end else begin
            unique case (count_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_e;
                        count_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_e;
                    end else if (accept) begin
                        skid_d  = in_e;
                        count_d = FULL;
                    end else if (pop) begin
                        count_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        count_d = ONE;
                    end
                end
                default: count_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule
